// File: rtl/mealy_pattern_detector.sv
// -----------------------------------------------------------------------------
// mealy_pattern_detector
//
// Serial pattern detector. It watches a bit stream and flags each occurrence
// of a programmable PAT_LEN-bit pattern. The first bit received is the MSB of
// the pattern. This block generalises the single-bit Mealy zero detector: with
// PAT_LEN=2 and pattern 2'b10, y_out matches the legacy zero detector.
//
// Parameters
//   PAT_LEN      pattern length in bits, >= 2
//   PAT_DEFAULT  pattern loaded at reset
//   CNT_W        match counter width, >= 1
//
// Ports
//   clk        in   1        rising-edge clock
//   rstn       in   1        asynchronous active-low reset
//   x_in       in   1        serial data bit
//   x_valid    in   1        x_in is consumed this cycle when high
//   load       in   1        latch `pattern` and restart detection
//   pattern    in   PAT_LEN  new pattern, bit PAT_LEN-1 is received first
//   overlap    in   1        1: overlapping matches, 0: non-overlapping
//   clear      in   1        synchronous clear of match_cnt and cnt_sat
//   y_out      out  1        Mealy match flag, combinational from x_in
//   y_reg      out  1        y_out registered, 1-cycle latency
//   match_cnt  out  CNT_W    saturating count of matches
//   cnt_sat    out  1        high once match_cnt has reached all-ones
//
// Input qualification: a bit is consumed only in a cycle where
// x_valid=1 and load=0. No backpressure is applied, so there is no ready.
// -----------------------------------------------------------------------------
module mealy_pattern_detector #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = PAT_LEN'(4'b1010),
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               x_in,
    input  logic               x_valid,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    input  logic               clear,
    output logic               y_out,
    output logic               y_reg,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    // fill ranges over 0..PAT_LEN-1; keep at least one bit for PAT_LEN=2.
    localparam int                FILL_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-2:0] hist_q;   // last PAT_LEN-1 consumed bits, newest at bit 0
    logic [FILL_W-1:0]  fill_q;   // number of valid history bits, saturating

    logic               consume;
    logic               hist_full;
    logic [PAT_LEN-1:0] window;   // history plus the bit on x_in right now
    logic               hit;

    // ------------------------------------------------------------------
    // Match detection (Mealy: depends on the live x_in / x_valid)
    // ------------------------------------------------------------------
    assign consume   = x_valid & ~load;
    assign hist_full = (fill_q == FILL_MAX);
    assign window    = {hist_q, x_in};
    assign hit       = consume & hist_full & (window == pat_q);

    // Reset clears the history asynchronously, which already kills hit;
    // gating with rstn also keeps y_out low during the reset pulse itself.
    assign y_out = hit & rstn;

    // ------------------------------------------------------------------
    // Pattern register and history shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q  <= PAT_DEFAULT;
            hist_q <= '0;
            fill_q <= '0;
        end else if (load) begin
            // The bit on x_in in the load cycle is deliberately dropped.
            pat_q  <= pattern;
            hist_q <= '0;
            fill_q <= '0;
        end else if (x_valid) begin
            if (hit && !overlap) begin
                // Non-overlapping: the matched bits cannot seed the next
                // match, so the next one needs PAT_LEN fresh bits.
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= window[PAT_LEN-2:0];
                fill_q <= hist_full ? fill_q : fill_q + FILL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_reg <= 1'b0;
        end else begin
            y_reg <= hit;
        end
    end

    // ------------------------------------------------------------------
    // Saturating match counter. clear has priority over a coincident hit;
    // that hit still appears on y_out and y_reg.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (clear) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
            // Raised in the same cycle the count lands on all-ones.
            if (match_cnt == CNT_MAX - CNT_W'(1)) begin
                cnt_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_mealy_pattern_detector
//
// Drives two detector instances from the same stimulus: dut8 with all default
// parameters and dut2 with a 2-bit counter so saturation is reachable. Each
// stimulus record carries the expected Mealy flag; that value is also pushed
// into a queue and popped one clock later as the expected y_reg. Expected
// counter values come from a small saturating-counter model fed by the
// expected flags.
// -----------------------------------------------------------------------------
module tb_mealy_pattern_detector;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rstn;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic       x_in;
    logic       x_valid;
    logic       load;
    logic [3:0] pattern;
    logic       overlap;
    logic       clear;

    logic       y_out8, y_reg8, cnt_sat8;
    logic [7:0] match_cnt8;
    logic       y_out2, y_reg2, cnt_sat2;
    logic [1:0] match_cnt2;

    mealy_pattern_detector dut8 (
        .clk       (clk),
        .rstn      (rstn),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .load      (load),
        .pattern   (pattern),
        .overlap   (overlap),
        .clear     (clear),
        .y_out     (y_out8),
        .y_reg     (y_reg8),
        .match_cnt (match_cnt8),
        .cnt_sat   (cnt_sat8)
    );

    mealy_pattern_detector #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .load      (load),
        .pattern   (pattern),
        .overlap   (overlap),
        .clear     (clear),
        .y_out     (y_out2),
        .y_reg     (y_reg2),
        .match_cnt (match_cnt2),
        .cnt_sat   (cnt_sat2)
    );

    // ------------------------------------------------------------------
    // Stimulus records and scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        logic       x;
        logic       v;
        logic       ld;
        logic [3:0] pat;
        logic       ov;
        logic       clr;
        logic       exp_y;
    } vec_t;

    vec_t     tbl[$];
    logic     exp_q[$];

    int       n_checks = 0;
    int       n_fail   = 0;

    int       exp_cnt8;
    int       exp_cnt2;
    logic     exp_sat8;
    logic     exp_sat2;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic x, input logic v, input logic ld, input logic [3:0] pat,
                       input logic ov, input logic clr, input logic exp_y);
        vec_t t;
        t.x = x; t.v = v; t.ld = ld; t.pat = pat; t.ov = ov; t.clr = clr; t.exp_y = exp_y;
        tbl.push_back(t);
    endtask

    task automatic model_reset();
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        exp_sat8 = 1'b0;
        exp_sat2 = 1'b0;
        exp_q.delete();
    endtask

    // Saturating counter model, advanced with the expected flag of a cycle.
    task automatic model_count(input logic clr, input logic hit);
        if (clr) begin
            exp_cnt8 = 0; exp_sat8 = 1'b0;
            exp_cnt2 = 0; exp_sat2 = 1'b0;
        end else if (hit) begin
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt8 == 255) exp_sat8 = 1'b1;
            if (exp_cnt2 < 3) exp_cnt2++;
            if (exp_cnt2 == 3) exp_sat2 = 1'b1;
        end
    endtask

    // One clock: drive at negedge, check y_out mid-low-phase, check the
    // registered outputs just after the rising edge.
    task automatic step(input vec_t t);
        logic e;
        @(negedge clk);
        x_in    = t.x;
        x_valid = t.v;
        load    = t.ld;
        pattern = t.pat;
        overlap = t.ov;
        clear   = t.clr;
        #1;
        check("y_out",    {7'd0, y_out8}, {7'd0, t.exp_y});
        check("y_out_c2", {7'd0, y_out2}, {7'd0, t.exp_y});
        exp_q.push_back(t.exp_y);
        model_count(t.clr, t.exp_y);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            check("y_reg",    {7'd0, y_reg8}, {7'd0, e});
            check("y_reg_c2", {7'd0, y_reg2}, {7'd0, e});
        end
        check("match_cnt",    match_cnt8,        8'(exp_cnt8));
        check("cnt_sat",      {7'd0, cnt_sat8},  {7'd0, exp_sat8});
        check("match_cnt_c2", {6'd0, match_cnt2}, 8'(exp_cnt2));
        check("cnt_sat_c2",   {7'd0, cnt_sat2},  {7'd0, exp_sat2});
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end
        tbl.delete();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rstn    = 1'b0;
        x_in    = 1'b0;
        x_valid = 1'b0;
        load    = 1'b0;
        pattern = 4'b0000;
        overlap = 1'b1;
        clear   = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_y_out",     {7'd0, y_out8},    8'd0);
        check("rst_y_reg",     {7'd0, y_reg8},    8'd0);
        check("rst_match_cnt", match_cnt8,        8'd0);
        check("rst_cnt_sat",   {7'd0, cnt_sat8},  8'd0);
        check("rst_cnt_c2",    {6'd0, match_cnt2}, 8'd0);
        rstn = 1'b1;

        // Default pattern 1010, overlapping
        add(1,1,0,4'b1010,1,0,0);
        add(0,1,0,4'b1010,1,0,0);
        add(1,1,0,4'b1010,1,0,0);
        add(0,1,0,4'b1010,1,0,1);
        add(1,1,0,4'b1010,1,0,0);
        add(0,1,0,4'b1010,1,0,1);
        run_tbl();
        check("overlap_total", match_cnt8, 8'd2);

        // Same stream, non-overlapping (restart with load + clear)
        add(0,0,1,4'b1010,0,1,0);
        add(1,1,0,4'b1010,0,0,0);
        add(0,1,0,4'b1010,0,0,0);
        add(1,1,0,4'b1010,0,0,0);
        add(0,1,0,4'b1010,0,0,1);
        add(1,1,0,4'b1010,0,0,0);
        add(0,1,0,4'b1010,0,0,0);
        run_tbl();
        check("nonoverlap_total", match_cnt8, 8'd1);

        // x_valid gap: x_in=0 during the gap must not be consumed
        add(0,0,1,4'b1010,1,1,0);
        add(1,1,0,4'b1010,1,0,0);
        add(0,1,0,4'b1010,1,0,0);
        add(1,1,0,4'b1010,1,0,0);
        add(0,0,0,4'b1010,1,0,0);
        add(0,0,0,4'b1010,1,0,0);
        add(0,0,0,4'b1010,1,0,0);
        add(0,1,0,4'b1010,1,0,1);
        run_tbl();
        check("gap_total", match_cnt8, 8'd1);

        // Reset pulsed mid-stream, with the completing 0 already presented
        add(0,0,1,4'b0110,1,1,0);   // load a different pattern first
        add(0,0,1,4'b1010,1,0,0);
        add(1,1,0,4'b1010,1,0,0);
        add(0,1,0,4'b1010,1,0,0);
        add(1,1,0,4'b1010,1,0,0);
        run_tbl();
        check("pre_reset_cnt", match_cnt8, 8'd0);
        @(negedge clk);
        x_in    = 1'b0;
        x_valid = 1'b1;
        rstn    = 1'b0;
        #1;
        model_reset();
        check("midrst_y_out",     {7'd0, y_out8},    8'd0);
        check("midrst_y_reg",     {7'd0, y_reg8},    8'd0);
        check("midrst_match_cnt", match_cnt8,        8'd0);
        check("midrst_cnt_c2",    {6'd0, match_cnt2}, 8'd0);
        #2;
        rstn    = 1'b1;
        x_valid = 1'b0;
        // After reset the default pattern 1010 is back in force
        add(0,1,0,4'b0000,1,0,0);
        add(1,1,0,4'b0000,1,0,0);
        add(0,1,0,4'b0000,1,0,0);
        add(1,1,0,4'b0000,1,0,0);
        add(0,1,0,4'b0000,1,0,1);
        run_tbl();

        // Load 1111 with a 1 in the load cycle that must be dropped
        add(1,1,1,4'b1111,1,0,0);
        add(1,1,0,4'b1111,1,0,0);
        add(1,1,0,4'b1111,1,0,0);
        add(1,1,0,4'b1111,1,0,0);
        add(1,1,0,4'b1111,1,0,1);
        add(1,1,0,4'b1111,1,0,1);
        run_tbl();
        check("load_total", match_cnt8, 8'd3);

        // Saturation of the 2-bit counter
        add(0,0,0,4'b1111,1,1,0);
        add(1,1,0,4'b1111,1,0,1);
        add(1,1,0,4'b1111,1,0,1);
        add(1,1,0,4'b1111,1,0,1);
        add(1,1,0,4'b1111,1,0,1);
        run_tbl();
        check("sat_cnt_c2", {6'd0, match_cnt2}, 8'd3);
        check("sat_flag_c2", {7'd0, cnt_sat2},  8'd1);
        check("sat_cnt_8",   match_cnt8,        8'd4);

        // clear coinciding with a hit: counter clears, flags still show the hit
        add(1,1,0,4'b1111,1,1,1);
        run_tbl();
        check("clrhit_cnt_c2", {6'd0, match_cnt2}, 8'd0);
        check("clrhit_sat_c2", {7'd0, cnt_sat2},  8'd0);
        check("clrhit_y_reg",  {7'd0, y_reg2},    8'd1);

        // Switching to non-overlapping mid-stream
        add(1,1,0,4'b1111,0,0,1);
        add(1,1,0,4'b1111,0,0,0);
        add(1,1,0,4'b1111,0,0,0);
        add(1,1,0,4'b1111,0,0,0);
        add(1,1,0,4'b1111,0,0,1);
        add(0,0,0,4'b1111,0,0,0);
        run_tbl();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
